jt10_adpcmb_mch: RTL and testbench
==================================

JT10_ADPCMB_MCH -- requirements
Module: jt10_adpcmb_mch

Interface
REQ-001 SHALL have parameter CHANNELS, default 1, number of time-multiplexed ADPCM-B channels (1..8).
REQ-002 SHALL have parameter XW, default 16, signed output/accumulator width (16..20).
REQ-003 SHALL have parameter MINSTEP, default 127, lower step clamp.
REQ-004 SHALL have parameter MAXSTEP, default 24576, upper step clamp.
REQ-005 SHALL derive localparam CHW = max(1, clog2(CHANNELS)).
REQ-006 clk  input  1  single clock; all state on posedge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 cen  input  1  clock enable; no state changes when low.
REQ-009 adv  input  1  request to decode one nibble.
REQ-010 adv_ch  input  CHW  channel index of the request.
REQ-011 data  input  4  ADPCM nibble: bit3 sign, bits2:0 magnitude.
REQ-012 chon  input  CHANNELS  per-channel enable.
REQ-013 ready  output  1  combinational; request on adv_ch acceptable this cycle.
REQ-014 pcm  output  XW  signed decoded sample.
REQ-015 pcm_ch  output  CHW  channel of pcm.
REQ-016 pcm_valid  output  1  one-cen-cycle strobe, pcm/pcm_ch valid.

Function
REQ-017 Request SHALL be accepted when cen & adv & ready; ready low SHALL drop the request (no capture).
REQ-018 ready SHALL be low when adv_ch >= CHANNELS, chon[adv_ch] = 0, or any pipeline stage holds adv_ch.
REQ-019 Per-channel state SHALL be x (XW signed) and step (15-bit unsigned), read at stage I.
REQ-020 Stage II: d = ((2*mag+1)*step) >> 3, 16 bits unsigned; for XW > 16, d SHALL be left-shifted by XW-16.
REQ-021 Stage II: nstep = (f*step) >> 6, f = 57 if mag < 4, else 77/102/128/153 for mag = 4/5/6/7.
REQ-022 Stage III: d SHALL be negated (two's complement) when sign = 1.
REQ-023 Stage IV: sum = x + d; on signed overflow x' SHALL saturate to +(2^(XW-1)-1) or -2^(XW-1).
REQ-024 Stage IV: step' = clamp(nstep, MINSTEP, MAXSTEP).
REQ-025 Stage V: x', step' written back; pcm = x', pcm_ch = channel, pcm_valid = 1.
REQ-026 Latency SHALL be 4 cen cycles from accept to pcm_valid; throughput one request per cen cycle across distinct channels.
REQ-027 If chon[ch] = 0 at writeback, the stage SHALL be discarded, with no pcm_valid.
REQ-028 Whenever chon[ch] = 0, channel state SHALL be forced to x = 0, step = MINSTEP.
REQ-029 pcm/pcm_ch SHALL hold their last value between strobes.
REQ-030 Channels SHALL be fully independent; no cross-channel state leakage.

Reset
REQ-031 rst_n low SHALL immediately clear all pipeline valid bits, all x = 0, all step = MINSTEP, pcm = 0, pcm_ch = 0, pcm_valid = 0.
REQ-032 In-flight requests at reset SHALL be lost, with no output after release.
REQ-033 ready SHALL be evaluable on the first cycle after release.

Structure
REQ-034 Shared package jt10_adpcmb_pkg SHALL hold the step-factor table (57, 77, 102, 128, 153) and the default MINSTEP/MAXSTEP.
REQ-035 Sub-module jt10_adpcmb_step SHALL hold the factor lookup, multiply, shift and clamp (stages II and IV step path).
REQ-036 Per-channel state SHALL be register arrays, not inferred RAM.

Verification
REQ-037 Reset, CHANNELS = 1, data = 0x7 -> after 4 cen cycles pcm = 238, pcm_valid = 1; step becomes 303.
REQ-038 Reset, data = 0x0 -> pcm = 15; step 113 clamped to 127.
REQ-039 Repeated 0x7 on one channel -> pcm monotonic, saturates at 32767 and never wraps; step clamps at 24576.
REQ-040 CHANNELS = 4, interleave ch0 = 0x7, ch1 = 0xF each cycle -> ch0 = +238, ch1 = -238 tagged correctly; same-channel back-to-back -> ready low for 4 cycles.
REQ-041 chon[2] dropped 2 cycles after accept on ch2 -> no pcm_valid for ch2; state x = 0, step = 127.
REQ-042 XW = 18, data = 0x7 from reset -> pcm = 952; rst_n pulsed mid-flight -> no pcm_valid afterwards.

Source files
------------

// File: rtl/jt10_adpcmb_pkg.sv
// rtl/jt10_adpcmb_pkg.sv - shared constants and step-factor table for the ADPCM-B decoder
// Contents: default step clamps, state widths, step-factor table and its lookup.
package jt10_adpcmb_pkg;

  localparam int DEF_MINSTEP = 127;
  localparam int DEF_MAXSTEP = 24576;
  localparam int STEP_W      = 15;  // per-channel step register width
  localparam int NSTEP_W     = 17;  // unclamped next step, wide enough for 153*24576/64
  localparam int FACTOR_W    = 8;

  typedef logic [STEP_W-1:0]  step_t;
  typedef logic [NSTEP_W-1:0] nstep_t;

  // Step multipliers in 1/64 units. Entry 0 serves magnitudes 0..3,
  // entries 1..4 serve magnitudes 4..7.
  localparam logic [FACTOR_W-1:0] STEP_FACTOR [5] = '{8'd57, 8'd77, 8'd102, 8'd128, 8'd153};

  function automatic logic [FACTOR_W-1:0] step_factor(input logic [2:0] mag);
    logic [2:0] idx;
    idx = mag[2] ? ({1'b0, mag[1:0]} + 3'd1) : 3'd0;
    return STEP_FACTOR[idx];
  endfunction

endpackage

// File: rtl/jt10_adpcmb_step.sv
// rtl/jt10_adpcmb_step.sv - step adaptation: factor lookup, scale, clamp
// Ports:
//   step         current channel step (stage II input)
//   mag          nibble magnitude selecting the factor
//   nstep        unclamped next step, (factor*step)>>6 (stage II result)
//   nstep_q      registered unclamped step arriving at stage IV
//   step_clamped nstep_q limited to [MINSTEP, MAXSTEP]
module jt10_adpcmb_step
  import jt10_adpcmb_pkg::*;
#(
  parameter int MINSTEP = DEF_MINSTEP,
  parameter int MAXSTEP = DEF_MAXSTEP
) (
  input  logic [STEP_W-1:0]  step,
  input  logic [2:0]         mag,
  output logic [NSTEP_W-1:0] nstep,
  input  logic [NSTEP_W-1:0] nstep_q,
  output logic [STEP_W-1:0]  step_clamped
);

  assign nstep = NSTEP_W'((23'(step_factor(mag)) * 23'(step)) >> 6);

  always_comb begin
    step_clamped = nstep_q[STEP_W-1:0];
    if (nstep_q < NSTEP_W'(MINSTEP)) begin
      step_clamped = STEP_W'(MINSTEP);
    end else if (nstep_q > NSTEP_W'(MAXSTEP)) begin
      step_clamped = STEP_W'(MAXSTEP);
    end
  end

endmodule

// File: rtl/jt10_adpcmb_mch.sv
// rtl/jt10_adpcmb_mch.sv - time-multiplexed multi-channel ADPCM-B nibble decoder
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cen          clock enable; pipeline and state frozen when low
//   adv, adv_ch  decode request and its channel
//   data         nibble: bit3 sign, bits2:0 magnitude
//   chon         per-channel enable; a disabled channel is held at x=0, step=MINSTEP
//   ready        combinational: a request on adv_ch would be accepted now
//   pcm, pcm_ch  last decoded sample and its channel
//   pcm_valid    one-cen-cycle strobe for a new pcm/pcm_ch
// Pipeline: I read state, II magnitude/step scale, III sign, IV saturate/clamp,
// writeback on the following cen edge (4 cen cycles from accept to pcm_valid).
module jt10_adpcmb_mch
  import jt10_adpcmb_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int XW       = 16,
  parameter int MINSTEP  = DEF_MINSTEP,
  parameter int MAXSTEP  = DEF_MAXSTEP,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 adv,
  input  logic [CHW-1:0]       adv_ch,
  input  logic [3:0]           data,
  input  logic [CHANNELS-1:0]  chon,
  output logic                 ready,
  output logic signed [XW-1:0] pcm,
  output logic [CHW-1:0]       pcm_ch,
  output logic                 pcm_valid
);

  localparam int NCH = 1 << CHW;  // state arrays cover every adv_ch code
  localparam int AW  = XW + 2;    // headroom for x + d before saturation
  localparam logic signed [AW-1:0] X_MAX = {3'b000, {(XW-1){1'b1}}};
  localparam logic signed [AW-1:0] X_MIN = {3'b111, {(XW-1){1'b0}}};

  // Channels beyond CHANNELS read as permanently disabled.
  logic [NCH-1:0] chon_pad;
  always_comb begin
    chon_pad = '0;
    chon_pad[CHANNELS-1:0] = chon;
  end

  logic signed [XW-1:0] x_r    [NCH];
  logic [STEP_W-1:0]    step_r [NCH];

  logic                 s1_v, s2_v, s3_v, s4_v;
  logic [CHW-1:0]       s1_ch, s2_ch, s3_ch, s4_ch;
  logic                 s1_sign, s2_sign;
  logic [2:0]           s1_mag;
  logic signed [XW-1:0] s1_x, s2_x, s3_x, s4_x;
  logic [STEP_W-1:0]    s1_step, s4_step;
  logic signed [AW-1:0] s2_d, s3_dn;
  logic [NSTEP_W-1:0]   s2_nstep, s3_nstep;

  logic                 busy;
  logic                 accept;
  logic [15:0]          d16;
  logic signed [AW-1:0] d_scaled;
  logic signed [AW-1:0] sum;
  logic signed [XW-1:0] x_sat;
  logic [NSTEP_W-1:0]   nstep;
  logic [STEP_W-1:0]    step_clamped;
  logic                 wb;

  // A channel already in flight would read stale state, so it is refused.
  always_comb begin
    busy  = (s1_v && (s1_ch == adv_ch)) || (s2_v && (s2_ch == adv_ch)) ||
            (s3_v && (s3_ch == adv_ch)) || (s4_v && (s4_ch == adv_ch));
    ready = (32'(adv_ch) < 32'(CHANNELS)) && chon_pad[adv_ch] && !busy;
  end

  assign accept = cen && adv && ready;

  // Stage II datapath: delta magnitude, widened and scaled to the output width.
  assign d16      = 16'((19'({s1_mag, 1'b1}) * 19'(s1_step)) >> 3);
  assign d_scaled = AW'(d16) << (XW - 16);

  jt10_adpcmb_step #(
    .MINSTEP (MINSTEP),
    .MAXSTEP (MAXSTEP)
  ) u_step (
    .step         (s1_step),
    .mag          (s1_mag),
    .nstep        (nstep),
    .nstep_q      (s3_nstep),
    .step_clamped (step_clamped)
  );

  // Stage IV datapath: accumulate and saturate instead of wrapping.
  assign sum = {{2{s3_x[XW-1]}}, s3_x} + s3_dn;
  always_comb begin
    x_sat = sum[XW-1:0];
    if (sum > X_MAX) begin
      x_sat = X_MAX[XW-1:0];
    end else if (sum < X_MIN) begin
      x_sat = X_MIN[XW-1:0];
    end
  end

  assign wb = s4_v && chon_pad[s4_ch];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0; s4_v <= 1'b0;
      s1_ch <= '0; s2_ch <= '0; s3_ch <= '0; s4_ch <= '0;
      s1_sign <= 1'b0; s2_sign <= 1'b0; s1_mag <= '0;
      s1_x <= '0; s2_x <= '0; s3_x <= '0; s4_x <= '0;
      s1_step <= '0; s4_step <= '0;
      s2_d <= '0; s3_dn <= '0;
      s2_nstep <= '0; s3_nstep <= '0;
    end else if (cen) begin
      s1_v <= accept;
      if (accept) begin
        s1_ch   <= adv_ch;
        s1_sign <= data[3];
        s1_mag  <= data[2:0];
        s1_x    <= x_r[adv_ch];
        s1_step <= step_r[adv_ch];
      end
      s2_v     <= s1_v;
      s2_ch    <= s1_ch;
      s2_sign  <= s1_sign;
      s2_x     <= s1_x;
      s2_d     <= d_scaled;
      s2_nstep <= nstep;

      s3_v     <= s2_v;
      s3_ch    <= s2_ch;
      s3_x     <= s2_x;
      s3_dn    <= s2_sign ? -s2_d : s2_d;
      s3_nstep <= s2_nstep;

      s4_v     <= s3_v;
      s4_ch    <= s3_ch;
      s4_x     <= x_sat;
      s4_step  <= step_clamped;
    end
  end

  // Per-channel state. Disabling a channel overrides any pending writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        x_r[i]    <= '0;
        step_r[i] <= STEP_W'(MINSTEP);
      end
    end else if (cen) begin
      for (int i = 0; i < NCH; i++) begin
        if (!chon_pad[i]) begin
          x_r[i]    <= '0;
          step_r[i] <= STEP_W'(MINSTEP);
        end else if (s4_v && (s4_ch == CHW'(i))) begin
          x_r[i]    <= s4_x;
          step_r[i] <= s4_step;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm       <= '0;
      pcm_ch    <= '0;
      pcm_valid <= 1'b0;
    end else if (cen) begin
      pcm_valid <= wb;
      if (wb) begin
        pcm    <= s4_x;
        pcm_ch <= s4_ch;
      end
    end
  end

endmodule

// File: tb/tb_jt10_adpcmb_mch.sv
// tb/tb_jt10_adpcmb_mch.sv - self-checking bench for jt10_adpcmb_mch
module tb_jt10_adpcmb_mch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cen;

  logic adv_a; logic [1:0] ch_a; logic [3:0] data_a; logic [3:0] chon_a;
  logic ready_a; logic signed [15:0] pcm_a; logic [1:0] pcm_ch_a; logic pcm_valid_a;

  logic adv_b; logic [0:0] ch_b; logic [3:0] data_b; logic [0:0] chon_b;
  logic ready_b; logic signed [17:0] pcm_b; logic [0:0] pcm_ch_b; logic pcm_valid_b;

  jt10_adpcmb_mch #(.CHANNELS(4), .XW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .cen(cen), .adv(adv_a), .adv_ch(ch_a), .data(data_a),
    .chon(chon_a), .ready(ready_a), .pcm(pcm_a), .pcm_ch(pcm_ch_a), .pcm_valid(pcm_valid_a)
  );

  jt10_adpcmb_mch #(.CHANNELS(1), .XW(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .cen(cen), .adv(adv_b), .adv_ch(ch_b), .data(data_b),
    .chon(chon_b), .ready(ready_b), .pcm(pcm_b), .pcm_ch(pcm_ch_b), .pcm_valid(pcm_valid_b)
  );

  // Reference model: unit 0 is dut_a (4 ch, XW 16), unit 1 is dut_b (1 ch, XW 18).
  typedef struct { int u; int due; int ch; int pcm; } ent_t;
  ent_t q[$];
  int mx  [2][4];
  int mst [2][4];
  int exp_valid [2];
  int exp_pcm   [2];
  int exp_ch    [2];
  int cen_n;
  int checks;
  int failures;
  int prev;

  task automatic chk(input string tag, input integer obs, input integer expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int decode(input int u, input int ch, input logic [3:0] nib);
    int mag, d, s, f, ns, hi;
    mag = int'(nib[2:0]);
    d = ((2 * mag + 1) * mst[u][ch]) / 8;
    if (u == 1) d = d * 4;
    if (nib[3]) d = -d;
    hi = (u == 1) ? 131071 : 32767;
    s = mx[u][ch] + d;
    if (s > hi) s = hi;
    else if (s < -hi - 1) s = -hi - 1;
    mx[u][ch] = s;
    case (mag)
      4: f = 77;
      5: f = 102;
      6: f = 128;
      7: f = 153;
      default: f = 57;
    endcase
    ns = (f * mst[u][ch]) / 64;
    if (ns < 127) ns = 127;
    if (ns > 24576) ns = 24576;
    mst[u][ch] = ns;
    return s;
  endfunction

  function automatic bit busy(input int u, input int ch);
    foreach (q[i]) if (q[i].u == u && q[i].ch == ch) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit chon_of(input int u, input int ch);
    if (u == 0) return chon_a[ch];
    return chon_b[0];
  endfunction

  function automatic bit exp_ready(input int u);
    if (u == 0) return chon_a[ch_a] && !busy(0, int'(ch_a));
    return (ch_b == 1'b0) && chon_b[0] && !busy(1, 0);
  endfunction

  task automatic model_clear();
    q.delete();
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 4; c++) begin
        mx[u][c] = 0;
        mst[u][c] = 127;
      end
      exp_valid[u] = 0; exp_pcm[u] = 0; exp_ch[u] = 0;
    end
  endtask

  task automatic model_edge();
    bit r0, r1;
    int p;
    r0 = exp_ready(0);
    r1 = exp_ready(1);
    cen_n++;
    exp_valid[0] = 0;
    exp_valid[1] = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cen_n) begin
        if (chon_of(q[i].u, q[i].ch)) begin
          exp_valid[q[i].u] = 1;
          exp_pcm[q[i].u]   = q[i].pcm;
          exp_ch[q[i].u]    = q[i].ch;
        end
        q.delete(i);
      end
    end
    if (adv_a && r0) begin
      p = decode(0, int'(ch_a), data_a);
      q.push_back('{0, cen_n + 4, int'(ch_a), p});
    end
    if (adv_b && r1) begin
      p = decode(1, 0, data_b);
      q.push_back('{1, cen_n + 4, 0, p});
    end
    for (int c = 0; c < 4; c++) begin
      if (!chon_a[c]) begin mx[0][c] = 0; mst[0][c] = 127; end
    end
    if (!chon_b[0]) begin mx[1][0] = 0; mst[1][0] = 127; end
  endtask

  task automatic check_outputs();
    chk("ready_a", ready_a, exp_ready(0));
    chk("pcm_valid_a", pcm_valid_a, exp_valid[0]);
    chk("pcm_a", pcm_a, exp_pcm[0]);
    chk("pcm_ch_a", pcm_ch_a, exp_ch[0]);
    chk("ready_b", ready_b, exp_ready(1));
    chk("pcm_valid_b", pcm_valid_b, exp_valid[1]);
    chk("pcm_b", pcm_b, exp_pcm[1]);
    chk("pcm_ch_b", pcm_ch_b, exp_ch[1]);
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (rst_n && cen) model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pcm_valid_a", pcm_valid_a, 0);
    chk("rst_pcm_a", pcm_a, 0);
    chk("rst_pcm_ch_a", pcm_ch_a, 0);
    chk("rst_pcm_valid_b", pcm_valid_b, 0);
    chk("rst_pcm_b", pcm_b, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; cen_n = 0;
    rst_n = 1'b1; cen = 1'b0;
    adv_a = 1'b0; ch_a = '0; data_a = '0; chon_a = '0;
    adv_b = 1'b0; ch_b = '0; data_b = '0; chon_b = '0;
    model_clear();
    #2;
    do_reset();

    cen = 1'b1; chon_a = 4'hF; chon_b = 1'b1;

    // Out-of-range channel on the single-channel instance is never ready.
    ch_b = 1'b1; #1;
    chk("ready_b_out_of_range", ready_b, 0);
    ch_b = 1'b0; #1;
    chk("ready_b_in_range", ready_b, 1);

    // 0x7 from reset: 238 at XW 16, 952 at XW 18; same channel blocked 4 cycles.
    adv_a = 1'b1; ch_a = 2'd0; data_a = 4'h7;
    adv_b = 1'b1; data_b = 4'h7;
    tick();
    adv_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("same_ch_blocked", ready_a, 0);
      tick();
    end
    chk("same_ch_ready_again", ready_a, 1);
    chk("first_valid_a", pcm_valid_a, 1);
    chk("first_pcm_a", pcm_a, 238);
    chk("first_pcm_ch_a", pcm_ch_a, 0);
    chk("first_valid_b", pcm_valid_b, 1);
    chk("first_pcm_b", pcm_b, 952);
    adv_a = 1'b0;

    // 0x0 twice: 15 then 30, showing the step stayed clamped at 127.
    for (int k = 0; k < 2; k++) begin
      adv_a = 1'b1; ch_a = 2'd1; data_a = 4'h0;
      tick();
      adv_a = 1'b0;
      repeat (4) tick();
      chk("zero_nibble_pcm", pcm_a, (k == 0) ? 15 : 30);
      chk("zero_nibble_ch", pcm_ch_a, 1);
    end

    // Interleaved channels with opposite signs.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      adv_a = ((i % 5) != 4);
      ch_a = 2'(i % 5);
      data_a = ((i % 2) == 1) ? 4'hF : 4'h7;
      tick();
      if (i == 4) begin
        chk("interleave_ch0_pcm", pcm_a, 238);
        chk("interleave_ch0_tag", pcm_ch_a, 0);
      end
      if (i == 5) begin
        chk("interleave_ch1_pcm", pcm_a, -238);
        chk("interleave_ch1_tag", pcm_ch_a, 1);
      end
    end
    adv_a = 1'b0;

    // Repeated 0x7: monotonic, saturating, step clamped at MAXSTEP.
    do_reset();
    adv_a = 1'b1; ch_a = 2'd0; data_a = 4'h7;
    prev = -40000;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pcm_valid_a) begin
        chk("monotonic", (int'(pcm_a) >= prev), 1);
        prev = int'(pcm_a);
      end
    end
    adv_a = 1'b0;
    repeat (5) tick();
    chk("saturated_pcm", pcm_a, 32767);
    adv_a = 1'b1; data_a = 4'hF;
    tick();
    adv_a = 1'b0;
    repeat (4) tick();
    chk("after_sat_negative", pcm_a, -13313);

    // Channel disabled while in flight: no output, state restored to defaults.
    adv_a = 1'b1; ch_a = 2'd2; data_a = 4'h7;
    tick();
    adv_a = 1'b0;
    tick();
    chon_a[2] = 1'b0;
    repeat (4) tick();
    chk("dropped_no_valid", pcm_valid_a, 0);
    chk("dropped_pcm_held", pcm_a, -13313);
    chon_a[2] = 1'b1;
    tick();
    adv_a = 1'b1;
    tick();
    adv_a = 1'b0;
    repeat (4) tick();
    chk("reenabled_pcm", pcm_a, 238);
    chk("reenabled_ch", pcm_ch_a, 2);

    // Reset while requests are in flight.
    adv_a = 1'b1; ch_a = 2'd3; data_a = 4'h7;
    adv_b = 1'b1; data_b = 4'h5;
    tick();
    adv_a = 1'b0; adv_b = 1'b0;
    tick();
    do_reset();
    chk("ready_after_release", ready_a, 1);
    repeat (6) tick();
    chk("midflight_no_valid_a", pcm_valid_a, 0);
    chk("midflight_no_valid_b", pcm_valid_b, 0);
    chk("midflight_pcm_b", pcm_b, 0);

    // Randomized traffic with clock-enable gaps.
    for (int i = 0; i < 500; i++) begin
      cen    = (($urandom % 4) != 0);
      adv_a  = 1'($urandom % 2);
      ch_a   = 2'($urandom % 4);
      data_a = 4'($urandom);
      adv_b  = 1'($urandom % 2);
      ch_b   = 1'(($urandom % 4) == 0);
      data_b = 4'($urandom);
      tick();
    end
    cen = 1'b1; adv_a = 1'b0; adv_b = 1'b0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
